// File: rtl/dsp_sample_loader.sv
// Ping-pong frame loader for DSP Data Memory Bank I: writes the incoming sample stream
// into two frame buffers, hands full frames to the DSP in fill order, and counts drops.
module dsp_sample_loader #(
  parameter int          FRAME_LEN = 256,
  parameter logic [15:0] BASE_A    = 16'h0000,
  parameter logic [15:0] BASE_B    = 16'h0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] sample_in_i,
  input  logic        sample_valid_i,
  output logic [15:0] write_addr_o,
  output logic [31:0] write_data_o,
  output logic        write_en_o,
  output logic        frame_ready_o,
  output logic [15:0] frame_base_o,
  input  logic        frame_ack_i,
  output logic        overrun_o,
  output logic [15:0] drop_count_o
);
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  generate
    if (FRAME_LEN < 2 || FRAME_LEN > 65536 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_len
      $error("FRAME_LEN must be a power of two in 2..65536");
    end
    if (!((int'(BASE_A) + FRAME_LEN <= int'(BASE_B)) || (int'(BASE_B) + FRAME_LEN <= int'(BASE_A)))) begin : g_overlap
      $error("frame buffers A and B overlap");
    end
  endgenerate

  typedef enum logic {S_FILL, S_STALL} state_t;

  state_t           state_q, state_d;
  logic [1:0]       full_q, full_d, full_ack;
  logic             fill_sel_q, fill_sel_d;
  logic             oldest_q, oldest_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      drop_q, drop_d;
  logic             ack_ok, accept, done;
  logic [15:0]      fill_base;

  // An ack is only honoured against the frame the DSP can currently see.
  assign ack_ok    = frame_ack_i & frame_ready_o;
  assign accept    = sample_valid_i & (state_q == S_FILL);
  assign done      = accept & (wr_idx_q == LAST_IDX);
  assign fill_base = fill_sel_q ? BASE_B : BASE_A;

  always_comb begin
    full_ack = full_q;
    if (ack_ok) full_ack[oldest_q] = 1'b0;
    full_d     = full_ack;
    fill_sel_d = fill_sel_q;
    wr_idx_d   = wr_idx_q;
    oldest_d   = ack_ok ? ~oldest_q : oldest_q;
    state_d    = state_q;
    overrun_d  = overrun_q;
    drop_d     = drop_q;
    case (state_q)
      S_FILL: begin
        if (accept) wr_idx_d = wr_idx_q + IDX_W'(1);
        if (done) begin
          full_d[fill_sel_q] = 1'b1;
          // The ack has already been applied, so a buffer freed this cycle is reusable.
          if (full_ack[~fill_sel_q]) begin
            state_d  = S_STALL;
            oldest_d = ~fill_sel_q;
          end else begin
            fill_sel_d = ~fill_sel_q;
            oldest_d   = fill_sel_q;
          end
        end
      end
      S_STALL: begin
        if (sample_valid_i) begin
          overrun_d = 1'b1;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
        if (ack_ok) begin
          fill_sel_d = oldest_q;
          wr_idx_d   = '0;
          state_d    = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_FILL;
      full_q        <= 2'b00;
      fill_sel_q    <= 1'b0;
      oldest_q      <= 1'b0;
      wr_idx_q      <= '0;
      overrun_q     <= 1'b0;
      drop_q        <= 16'h0000;
      write_en_o    <= 1'b0;
      write_addr_o  <= 16'h0000;
      write_data_o  <= 32'h0;
      frame_ready_o <= 1'b0;
      frame_base_o  <= 16'h0000;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      fill_sel_q    <= fill_sel_d;
      oldest_q      <= oldest_d;
      wr_idx_q      <= wr_idx_d;
      overrun_q     <= overrun_d;
      drop_q        <= drop_d;
      write_en_o    <= accept;
      if (accept) begin
        write_addr_o <= fill_base + 16'(wr_idx_q);
        write_data_o <= sample_in_i;
      end
      // frame_ready dips for one cycle after every accepted ack.
      frame_ready_o <= (|full_d) & ~ack_ok;
      frame_base_o  <= oldest_d ? BASE_B : BASE_A;
    end
  end

  assign overrun_o    = overrun_q;
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_dsp_sample_loader.sv
// Directed bench for dsp_sample_loader: a queue-based frame model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_dsp_sample_loader;
  localparam int          LEN = 4;
  localparam logic [15:0] BA  = 16'h0000;
  localparam logic [15:0] BB  = 16'h0010;

  logic        clk = 0, rst = 1;
  logic [31:0] sample_in = 0;
  logic        sample_valid = 0, frame_ack = 0;
  logic [15:0] write_addr, frame_base, drop_count;
  logic [31:0] write_data;
  logic        write_en, frame_ready, overrun;

  dsp_sample_loader #(.FRAME_LEN(LEN), .BASE_A(BA), .BASE_B(BB)) dut (
    .clk_i(clk), .rst_i(rst), .sample_in_i(sample_in), .sample_valid_i(sample_valid),
    .write_addr_o(write_addr), .write_data_o(write_data), .write_en_o(write_en),
    .frame_ready_o(frame_ready), .frame_base_o(frame_base), .frame_ack_i(frame_ack),
    .overrun_o(overrun), .drop_count_o(drop_count));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit mon_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of full buffers in fill order, the buffer being filled and its index.
  int          q[$];
  int          fill, idx, freed;
  longint      drops;
  bit          stalled, ack_ok;
  logic        e_we, e_ready;
  logic [15:0] e_addr, e_base;
  logic [31:0] e_data;

  function automatic logic [15:0] base_of(input int b);
    return (b == 0) ? BA : BB;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); fill = 0; idx = 0; drops = 0;
      e_we = 0; e_ready = 0; e_addr = 0; e_base = 0; e_data = 0;
    end else begin
      stalled = (q.size() == 2);
      ack_ok  = frame_ack && e_ready;
      if (ack_ok) begin freed = q[0]; q.pop_front(); end
      e_we = 0;
      if (sample_valid && !stalled) begin
        e_we = 1; e_addr = base_of(fill) + 16'(idx); e_data = sample_in;
        idx++;
        if (idx == LEN) begin
          q.push_back(fill); idx = 0;
          if (q.size() < 2) fill = 1 - fill;
        end
      end else if (sample_valid) drops++;
      if (stalled && ack_ok) begin fill = freed; idx = 0; end
      e_ready = (q.size() > 0) && !ack_ok;
      if (q.size() > 0) e_base = base_of(q[0]);
    end
  end

  always @(negedge clk) if (mon_on) begin
    chk("write_en", write_en, e_we);
    if (e_we) begin
      chk("write_addr", write_addr, e_addr);
      chk("write_data", write_data, e_data);
    end
    chk("frame_ready", frame_ready, e_ready);
    if (e_ready) chk("frame_base", frame_base, e_base);
    chk("overrun", overrun, drops > 0);
    chk("drop_count", drop_count, (drops > 65535) ? 16'hFFFF : 16'(drops));
  end

  // One clock: inputs applied, then the edge, then outputs of that edge are visible.
  task automatic cyc(input logic v, input logic [31:0] d, input logic a, input logic r);
    sample_valid = v; sample_in = d; frame_ack = a; rst = r;
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [31:0] d);
    cyc(1, d, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 1);
    mon_on = 1;
    chk("rst_we", write_en, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_base", frame_base, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_drops", drop_count, 0);

    // Single frame
    send(32'hA0);
    chk("s1_addr0", write_addr, 16'h0000);
    chk("s1_ready0", frame_ready, 0);
    send(32'hA1); send(32'hA2); send(32'hA3);
    chk("s1_addr3", write_addr, 16'h0003);
    chk("s1_data3", write_data, 32'hA3);
    chk("s1_ready", frame_ready, 1);
    chk("s1_base", frame_base, 16'h0000);

    // Ping-pong
    send(32'hB0);
    chk("pp_addr4", write_addr, 16'h0010);
    send(32'hB1); send(32'hB2); send(32'hB3);
    chk("pp_addr7", write_addr, 16'h0013);
    cyc(0, 0, 1, 0);
    chk("pp_drop", frame_ready, 0);
    cyc(0, 0, 0, 0);
    chk("pp_rerise", frame_ready, 1);
    chk("pp_base", frame_base, 16'h0010);

    // Overrun
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 11; i++) send(32'hC00 + 32'(i));
    chk("ov_flag", overrun, 1);
    chk("ov_count", drop_count, 16'd3);
    cyc(0, 0, 1, 0);
    send(32'hCAFE);
    chk("ov_we", write_en, 1);
    chk("ov_addr", write_addr, 16'h0000);

    // Same-cycle completion and ack
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) send(32'hD00 + 32'(i));
    cyc(0, 0, 1, 0);
    send(32'hD10); send(32'hD11); send(32'hD12);
    chk("sc_base_b", frame_base, 16'h0010);
    cyc(1, 32'hD13, 1, 0);
    chk("sc_addr", write_addr, 16'h0003);
    chk("sc_nodrop", drop_count, 0);
    send(32'hD14);
    chk("sc_next", write_addr, 16'h0010);
    chk("sc_ready", frame_ready, 1);
    chk("sc_base_a", frame_base, 16'h0000);
    chk("sc_ovr", overrun, 0);

    // Reset mid-frame
    cyc(0, 0, 0, 1);
    send(32'hE0); send(32'hE1);
    cyc(1, 32'hE2, 1, 1);
    chk("rm_we", write_en, 0);
    chk("rm_addr", write_addr, 0);
    chk("rm_data", write_data, 0);
    chk("rm_ready", frame_ready, 0);
    send(32'hE3);
    chk("rm_first", write_addr, 16'h0000);
    send(32'hE4); send(32'hE5);
    chk("rm_notyet", frame_ready, 0);
    send(32'hE6);
    chk("rm_ready4", frame_ready, 1);

    // Saturation
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) send(32'hF0 + 32'(i));
    for (int i = 0; i < 65540; i++) send(32'(i));
    chk("sat_count", drop_count, 16'hFFFF);
    chk("sat_ovr", overrun, 1);
    cyc(0, 0, 0, 0);

    mon_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
